lpc_decoder_arbiter: RTL and testbench
======================================

Name: lpc_decoder_arbiter

Overview:
Shares one lpc_decoder instance between NUM_CH independent AXI-Stream sources of 80-bit LPC-coded words. The arbiter grants the decoder input one whole frame at a time, from first word to TLAST. It tags forwarded words with channel and start-of-frame information and drives the decoder EN. A word-count watchdog (FRAME_WORDS, 1920) bounds every grant so a stalled or malformed source cannot hold the decoder.

Parameters:
NUM_CH, 4, number of requesting source streams (2..8)
DATA_W, 80, coded word width per source
FRAME_WORDS, 1920, maximum words per frame before forced release
CH_W, $clog2(NUM_CH), channel id width

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  reset, synchronous, active-high
S_TDATA  in  NUM_CH*DATA_W  source words, channel i at [i*DATA_W +: DATA_W]
S_TVALID  in  NUM_CH  per-source valid
S_TLAST  in  NUM_CH  per-source end of frame
S_TREADY  out  NUM_CH  per-source ready
M_TDATA  out  DATA_W  to decoder TDATA
M_TVALID  out  1  to decoder TVALID
M_TLAST  out  1  to decoder TLAST; also asserted on the forced-release word
M_TUSER  out  1  high on first word of each granted frame
M_TREADY  in  1  from decoder TREADY
M_TDEST  out  CH_W  channel id of the current grant
DEC_EN  out  1  decoder enable, high while a frame is granted
FRAME_ERR  out  1  one-cycle pulse when the watchdog forces release
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset, while ARESET=1 at a clock edge:
  - State goes to IDLE.
  - Round-robin pointer is set so channel 0 has highest priority.
  - Word counter is cleared.
  - All outputs are 0, including S_TREADY, M_TVALID, DEC_EN and FRAME_ERR.
- Reset mid-frame:
  - The frame is abandoned and no TLAST is emitted.
  - The source keeps its remaining words, and they are presented again as a new frame.
- State IDLE:
  - S_TREADY=0, M_TVALID=0, DEC_EN=0.
  - If any S_TVALID is high, pick the winner by round-robin: search starts at the channel after the last granted one, lowest index first from that point.
  - Register the grant as gnt and go to XFER. Arbitration latency is 1 cycle.
- State XFER:
  - DEC_EN=1 and M_TDEST=gnt.
  - Pass-through, combinational from the registered gnt:
    - M_TDATA=S_TDATA[gnt], M_TVALID=S_TVALID[gnt].
    - S_TREADY[gnt]=M_TREADY. All other S_TREADY bits are 0.
  - M_TUSER=1 while the word counter is 0.
  - A transfer occurs when M_TVALID & M_TREADY. Each transfer increments the word counter.
  - M_TLAST = S_TLAST[gnt] | (count==FRAME_WORDS-1).
  - On a transfer with M_TLAST:
    - Clear the counter and set the round-robin pointer to gnt.
    - Go to IDLE. No back-to-back grant; there is always one IDLE cycle between frames.
  - If the forced limit is hit while S_TLAST[gnt]=0, pulse FRAME_ERR for the same cycle as the transfer.
  - S_TVALID[gnt] low: hold the grant indefinitely. The watchdog counts words only, not cycles.
- Non-granted sources are never acknowledged and must hold their data, per AXI rules.
- Simultaneous requests resolve by round-robin only, so no channel is starved: worst-case wait is (NUM_CH-1) frames.
- Word counter width is $clog2(FRAME_WORDS) bits. It never wraps because it is cleared at FRAME_WORDS-1.
- NUM_CH=1 degenerates to a pass-through with the one-cycle IDLE gap between frames.

Optional Feature:
LPC_ARB_FRAME_CNT_EN:
- Defined: adds output FRAME_CNT [NUM_CH*16-1:0].
  - Each channel has a 16-bit counter of completed frames, including forced ones.
  - Counters increment on the TLAST transfer, wrap at 0xFFFF→0, and clear on ARESET.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Package lpc_pkg holds:
  - LPC_DATA_W=80 and LPC_FRAME_WORDS=1920.
  - The arbiter state typedef: IDLE, XFER.
  - The channel-id width function.
- Sub-module lpc_rr_pick: combinational round-robin select.
  - Inputs: req[NUM_CH] and last[CH_W].
  - Outputs: gnt[CH_W] and any_req.
  - It is instantiated once, in IDLE selection.

Test Plan:
- Single source ch0, 3-word frame (TLAST on word 3), M_TREADY=1:
  - One IDLE cycle, then BUSY=1 and DEC_EN=1.
  - M_TUSER=1 on word 1 only, M_TLAST on word 3, M_TDEST=0.
  - Back to IDLE next cycle.
- Ch0..ch3 all valid together with 2-word frames:
  - Grant order is 0,1,2,3,0.
  - S_TREADY is one-hot to gnt every XFER cycle.
- Ch2 holds TLAST low for 2000 words:
  - M_TLAST and FRAME_ERR both high on word 1920.
  - Grant moves to the next requester; word 1921 starts a new frame with M_TUSER=1.
- Backpressure: M_TREADY toggles 1,0,0,1 mid-frame.
  - M_TDATA stays stable while M_TREADY=0.
  - Counter advances only on handshakes, and exactly N words are delivered.
- ARESET=1 asserted on word 5 of a 10-word ch1 frame:
  - All outputs are 0 next cycle.
  - After release, ch0 is serviced first if requesting.
- With LPC_ARB_FRAME_CNT_EN defined, run 3 frames on ch1:
  - FRAME_CNT[31:16]=3 and all other channel counts are 0.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared constants, arbiter state type and channel-id width helper for the
// LPC decoder arbiter slice.
package lpc_pkg;

    localparam int unsigned LPC_DATA_W      = 80;
    localparam int unsigned LPC_FRAME_WORDS = 1920;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Channel id width; a single channel still needs a one-bit id.
    function automatic int unsigned lpc_ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lpc_rr_pick.sv
// Combinational round-robin select: lowest requesting index strictly after
// 'last', wrapping around to the lowest requesting index overall.
module lpc_rr_pick
    import lpc_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = lpc_ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   gnt,
    output logic              any_req
);

    logic            hi_found;
    logic            lo_found;
    logic [CH_W-1:0] hi_gnt;
    logic [CH_W-1:0] lo_gnt;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_gnt   = '0;
        lo_gnt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && !hi_found && (CH_W'(i) > last)) begin
                hi_gnt   = CH_W'(i);
                hi_found = 1'b1;
            end
            if (req[i] && !lo_found) begin
                lo_gnt   = CH_W'(i);
                lo_found = 1'b1;
            end
        end
        gnt     = hi_found ? hi_gnt : lo_gnt;
        any_req = |req;
    end

endmodule

// File: rtl/lpc_decoder_arbiter.sv
// Frame-granular round-robin arbiter sharing one lpc_decoder between NUM_CH
// AXI-Stream sources. Define LPC_ARB_FRAME_CNT_EN for per-channel frame counters.
module lpc_decoder_arbiter
    import lpc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_W      = LPC_DATA_W,
    parameter int unsigned FRAME_WORDS = LPC_FRAME_WORDS,
    parameter int unsigned CH_W        = lpc_ch_w(NUM_CH)
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NUM_CH*DATA_W-1:0] S_TDATA,
    input  logic [NUM_CH-1:0]        S_TVALID,
    input  logic [NUM_CH-1:0]        S_TLAST,
    output logic [NUM_CH-1:0]        S_TREADY,
    output logic [DATA_W-1:0]        M_TDATA,
    output logic                     M_TVALID,
    output logic                     M_TLAST,
    output logic                     M_TUSER,
    input  logic                     M_TREADY,
    output logic [CH_W-1:0]          M_TDEST,
    output logic                     DEC_EN,
    output logic                     FRAME_ERR,
`ifdef LPC_ARB_FRAME_CNT_EN
    output logic [NUM_CH*16-1:0]     FRAME_CNT,
`endif
    output logic                     BUSY
);

    localparam int unsigned     CNT_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_WORDS - 1);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [CH_W-1:0]   gnt_q;
    logic [CH_W-1:0]   last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CH_W-1:0]   pick_gnt;
    logic              pick_any;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              cnt_hit;
    logic              xfer;
    logic              done;

    lpc_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req     (S_TVALID),
        .last    (last_q),
        .gnt     (pick_gnt),
        .any_req (pick_any)
    );

    // Mux the granted source onto the decoder side.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == gnt_q) begin
                sel_data  = S_TDATA[i*DATA_W +: DATA_W];
                sel_valid = S_TVALID[i];
                sel_last  = S_TLAST[i];
            end
        end
    end

    assign cnt_hit = (cnt_q == CNT_MAX);
    assign xfer    = (state == XFER) && sel_valid && M_TREADY;
    assign done    = xfer && (sel_last || cnt_hit);

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and pass-through outputs; everything is quiet outside XFER.
    always_comb begin
        state_nxt = state;
        S_TREADY  = '0;
        M_TDATA   = '0;
        M_TVALID  = 1'b0;
        M_TLAST   = 1'b0;
        M_TUSER   = 1'b0;
        M_TDEST   = '0;
        DEC_EN    = 1'b0;
        FRAME_ERR = 1'b0;
        BUSY      = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_any) state_nxt = XFER;
            end
            XFER: begin
                M_TDATA   = sel_data;
                M_TVALID  = sel_valid;
                M_TLAST   = sel_last || cnt_hit;
                M_TUSER   = (cnt_q == '0);
                M_TDEST   = gnt_q;
                DEC_EN    = 1'b1;
                FRAME_ERR = xfer && cnt_hit && !sel_last;
                for (int i = 0; i < NUM_CH; i++) begin
                    S_TREADY[i] = M_TREADY && (CH_W'(i) == gnt_q);
                end
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, round-robin pointer and watchdog word counter.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            gnt_q  <= '0;
            last_q <= CH_W'(NUM_CH - 1);
            cnt_q  <= '0;
        end else begin
            if ((state == IDLE) && pick_any) gnt_q <= pick_gnt;
            if (done) begin
                cnt_q  <= '0;
                last_q <= gnt_q;
            end else if (xfer) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef LPC_ARB_FRAME_CNT_EN
    logic [NUM_CH*16-1:0] fcnt_q;

    // Completed frames per channel, forced releases included; wraps naturally.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            fcnt_q <= '0;
        end else if (done) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CH_W'(i) == gnt_q) fcnt_q[i*16 +: 16] <= fcnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    assign FRAME_CNT = fcnt_q;
`endif

endmodule

// File: tb/tb_lpc_decoder_arbiter.sv
// Directed self-checking bench for lpc_decoder_arbiter (4 channels, 80-bit
// words, 1920-word watchdog); FRAME_CNT checked when LPC_ARB_FRAME_CNT_EN is set.
module tb_lpc_decoder_arbiter;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned DATA_W      = 80;
    localparam int unsigned FRAME_WORDS = 1920;
    localparam int unsigned CH_W        = 2;

    logic                     ACLK = 1'b0;
    logic                     ARESET = 1'b1;
    logic [NUM_CH*DATA_W-1:0] S_TDATA = '0;
    logic [NUM_CH-1:0]        S_TVALID = '0;
    logic [NUM_CH-1:0]        S_TLAST = '0;
    logic [NUM_CH-1:0]        S_TREADY;
    logic [DATA_W-1:0]        M_TDATA;
    logic                     M_TVALID;
    logic                     M_TLAST;
    logic                     M_TUSER;
    logic                     M_TREADY = 1'b0;
    logic [CH_W-1:0]          M_TDEST;
    logic                     DEC_EN;
    logic                     FRAME_ERR;
    logic                     BUSY;
`ifdef LPC_ARB_FRAME_CNT_EN
    logic [NUM_CH*16-1:0]     FRAME_CNT;
`endif

    lpc_decoder_arbiter #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .S_TDATA   (S_TDATA),
        .S_TVALID  (S_TVALID),
        .S_TLAST   (S_TLAST),
        .S_TREADY  (S_TREADY),
        .M_TDATA   (M_TDATA),
        .M_TVALID  (M_TVALID),
        .M_TLAST   (M_TLAST),
        .M_TUSER   (M_TUSER),
        .M_TREADY  (M_TREADY),
        .M_TDEST   (M_TDEST),
        .DEC_EN    (DEC_EN),
        .FRAME_ERR (FRAME_ERR),
`ifdef LPC_ARB_FRAME_CNT_EN
        .FRAME_CNT (FRAME_CNT),
`endif
        .BUSY      (BUSY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [CH_W-1:0]   dest;
        logic              user;
        logic              last;
        logic              err;
        logic [DATA_W-1:0] data;
    } mon_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned src_len    [NUM_CH];
    int unsigned src_frames [NUM_CH];
    int unsigned src_idx    [NUM_CH];
    int unsigned src_sent   [NUM_CH];
    mon_t        mon_q [$];
    logic        onehot_bad = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word_of(input int unsigned c, input int unsigned n);
        return DATA_W'({8'(c), 8'hA5, 32'(n)});
    endfunction

    task automatic drive_srcs();
        for (int c = 0; c < NUM_CH; c++) begin
            S_TVALID[c] = (src_frames[c] != 0);
            S_TLAST[c]  = (src_frames[c] != 0) && (src_idx[c] == src_len[c] - 1);
            S_TDATA[c*DATA_W +: DATA_W] = word_of(c, src_sent[c]);
        end
    endtask

    // One clock: sample both sides, advance the source models on their handshakes.
    task automatic step();
        logic [NUM_CH-1:0] hs;
        mon_t e;
        #1;
        hs = S_TVALID & S_TREADY;
        if (M_TVALID && M_TREADY) begin
            e.dest = M_TDEST; e.user = M_TUSER; e.last = M_TLAST;
            e.err  = FRAME_ERR; e.data = M_TDATA;
            mon_q.push_back(e);
        end
        if (BUSY && !$onehot0(S_TREADY)) onehot_bad = 1'b1;
        @(posedge ACLK);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hs[c]) begin
                src_sent[c]++;
                src_idx[c]++;
                if (src_idx[c] == src_len[c]) begin
                    src_idx[c] = 0;
                    src_frames[c]--;
                end
            end
        end
        drive_srcs();
        #1;
    endtask

    task automatic do_reset();
        ARESET   = 1'b1;
        M_TREADY = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            src_len[c] = 1; src_frames[c] = 0; src_idx[c] = 0; src_sent[c] = 0;
        end
        drive_srcs();
        step();
        step();
        ARESET = 1'b0;
        mon_q.delete();
        onehot_bad = 1'b0;
    endtask

    function automatic bit srcs_pending();
        bit p = 1'b0;
        for (int c = 0; c < NUM_CH; c++) if (src_frames[c] != 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_until_idle(input string tag, input int unsigned max_cyc, output int unsigned cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while ((srcs_pending() || BUSY) && cyc < max_cyc);
        check(tag, !(srcs_pending() || BUSY), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned cyc;
        int unsigned cnt [NUM_CH];
        int unsigned order [5] = '{0, 1, 2, 3, 0};
        int unsigned n_err, n_user, n_last;
        bit          ok;
        mon_t        e;

        // Reset state and a single 3-word frame on ch0
        do_reset();
        check("rst_s_tready", S_TREADY, 4'b0000);
        check("rst_m_tvalid", M_TVALID, 1'b0);
        check("rst_dec_en", DEC_EN, 1'b0);
        check("rst_frame_err", FRAME_ERR, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        src_len[0] = 3; src_frames[0] = 1; M_TREADY = 1'b1;
        drive_srcs();
        #1;
        check("t1_idle_busy", BUSY, 1'b0);
        check("t1_idle_tready", S_TREADY, 4'b0000);
        step();
        check("t1_w1_busy", BUSY, 1'b1);
        check("t1_w1_dec_en", DEC_EN, 1'b1);
        check("t1_w1_tuser", M_TUSER, 1'b1);
        check("t1_w1_tdest", M_TDEST, 2'd0);
        check("t1_w1_tlast", M_TLAST, 1'b0);
        check("t1_w1_tdata", M_TDATA, word_of(0, 0));
        check("t1_w1_tready", S_TREADY, 4'b0001);
        step();
        check("t1_w2_tuser", M_TUSER, 1'b0);
        check("t1_w2_tdata", M_TDATA, word_of(0, 1));
        step();
        check("t1_w3_tlast", M_TLAST, 1'b1);
        check("t1_w3_frame_err", FRAME_ERR, 1'b0);
        step();
        check("t1_after_busy", BUSY, 1'b0);
        check("t1_after_dec_en", DEC_EN, 1'b0);

        // All four channels request with 2-word frames; ch0 has a second frame
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin src_len[c] = 2; src_frames[c] = 1; cnt[c] = 0; end
        src_frames[0] = 2;
        M_TREADY = 1'b1;
        drive_srcs();
        run_until_idle("t2_done", 100, cyc);
        check("t2_cycles", cyc, 15);
        check("t2_words", mon_q.size(), 10);
        check("t2_onehot", onehot_bad, 1'b0);
        if (mon_q.size() == 10) begin
            for (int f = 0; f < 5; f++) begin
                for (int w = 0; w < 2; w++) begin
                    e = mon_q[f*2 + w];
                    check("t2_dest", e.dest, CH_W'(order[f]));
                    check("t2_user", e.user, (w == 0));
                    check("t2_last", e.last, (w == 1));
                    check("t2_data", e.data, word_of(order[f], cnt[order[f]]));
                    cnt[order[f]]++;
                end
            end
        end

        // Watchdog: ch2 runs 2000 words without TLAST, ch3 also requesting
        do_reset();
        src_len[2] = 2000; src_frames[2] = 1;
        src_len[3] = 2;    src_frames[3] = 1;
        M_TREADY = 1'b1;
        drive_srcs();
        run_until_idle("t3_done", 5000, cyc);
        check("t3_words", mon_q.size(), 2002);
        if (mon_q.size() == 2002) begin
            check("t3_w1919_last", mon_q[1918].last, 1'b0);
            check("t3_w1920_dest", mon_q[1919].dest, 2'd2);
            check("t3_w1920_last", mon_q[1919].last, 1'b1);
            check("t3_w1920_err", mon_q[1919].err, 1'b1);
            check("t3_next_dest", mon_q[1920].dest, 2'd3);
            check("t3_next_user", mon_q[1920].user, 1'b1);
            check("t3_w1921_dest", mon_q[1922].dest, 2'd2);
            check("t3_w1921_user", mon_q[1922].user, 1'b1);
            check("t3_w1921_data", mon_q[1922].data, word_of(2, 1920));
            check("t3_final_last", mon_q[2001].last, 1'b1);
            check("t3_final_err", mon_q[2001].err, 1'b0);
            n_err = 0; n_user = 0;
            foreach (mon_q[i]) begin
                if (mon_q[i].err)  n_err++;
                if (mon_q[i].user) n_user++;
            end
            check("t3_err_count", n_err, 1);
            check("t3_user_count", n_user, 3);
        end

        // Backpressure: M_TREADY follows 1,0,0,1 on a 6-word ch1 frame
        do_reset();
        src_len[1] = 6; src_frames[1] = 1;
        drive_srcs();
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            M_TREADY = (k % 4 == 0) || (k % 4 == 3);
            #1;
            if (BUSY) begin
                check("t4_data", M_TDATA, word_of(1, src_sent[1]));
                check("t4_user", M_TUSER, (src_idx[1] == 0));
                check("t4_last", M_TLAST, (src_idx[1] == 5));
            end
            if (src_frames[1] == 0 && !BUSY) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("t4_done", ok, 1'b1);
        check("t4_words", mon_q.size(), 6);
        if (mon_q.size() == 6) begin
            for (int w = 0; w < 6; w++) check("t4_mon_data", mon_q[w].data, word_of(1, w));
        end

        // Reset while ch1 presents word 5 of a 10-word frame
        do_reset();
        src_len[1] = 10; src_frames[1] = 1; M_TREADY = 1'b1;
        drive_srcs();
        for (int k = 0; k < 20 && src_sent[1] < 4; k++) step();
        check("t5_pre_sent", src_sent[1], 4);
        check("t5_pre_busy", BUSY, 1'b1);
        M_TREADY = 1'b0;
        ARESET = 1'b1;
        src_len[0] = 2; src_frames[0] = 1;
        drive_srcs();
        step();
        check("t5_rst_s_tready", S_TREADY, 4'b0000);
        check("t5_rst_m_tvalid", M_TVALID, 1'b0);
        check("t5_rst_m_tlast", M_TLAST, 1'b0);
        check("t5_rst_m_tuser", M_TUSER, 1'b0);
        check("t5_rst_m_tdest", M_TDEST, 2'd0);
        check("t5_rst_m_tdata", M_TDATA, 80'd0);
        check("t5_rst_dec_en", DEC_EN, 1'b0);
        check("t5_rst_frame_err", FRAME_ERR, 1'b0);
        check("t5_rst_busy", BUSY, 1'b0);
        n_last = 0;
        foreach (mon_q[i]) if (mon_q[i].last) n_last++;
        check("t5_no_tlast", n_last, 0);
        check("t5_pre_words", mon_q.size(), 4);
        ARESET = 1'b0;
        M_TREADY = 1'b1;
        mon_q.delete();
        run_until_idle("t5_done", 100, cyc);
        check("t5_words", mon_q.size(), 8);
        if (mon_q.size() == 8) begin
            check("t5_first_dest", mon_q[0].dest, 2'd0);
            check("t5_ch1_dest", mon_q[2].dest, 2'd1);
            check("t5_ch1_user", mon_q[2].user, 1'b1);
            check("t5_ch1_data", mon_q[2].data, word_of(1, 4));
            check("t5_ch1_last", mon_q[7].last, 1'b1);
        end

`ifdef LPC_ARB_FRAME_CNT_EN
        // Three frames on ch1 with the frame counters enabled
        do_reset();
        check("t6_rst_cnt", FRAME_CNT, 64'd0);
        src_len[1] = 2; src_frames[1] = 3; M_TREADY = 1'b1;
        drive_srcs();
        run_until_idle("t6_done", 100, cyc);
        check("t6_frame_cnt", FRAME_CNT, 64'h0000_0000_0003_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
